puf_majority_voter: RTL and testbench
=====================================

# puf_majority_voter

Temporal majority-vote stabiliser that sits directly downstream of the ring-oscillator PUF core. On a start request it enables the PUF, collects NUM_EVAL successive RESP_W-bit responses, and takes a per-bit majority vote. It delivers the stabilised key plus an unstable-bit mask over a valid/ready handshake to the key-consumer stage. A watchdog aborts the collection if the PUF stops producing responses.

## Interface
- RESP_W, 4, response width; equals number of RO pairs in the PUF core.
- NUM_EVAL, 7, evaluations per vote; odd, 3..255.
- TIMEOUT, 255, max cycles between responses in COLLECT; 1..65535.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a vote; honoured only in IDLE.
- puf_enable  out  1  drives PUF core enable; high only in COLLECT.
- resp_in  in  RESP_W  PUF response bits.
- resp_valid  in  1  one-cycle strobe: resp_in holds a new response.
- key_out  out  RESP_W  majority-voted key.
- unstable_mask  out  RESP_W  1 = bit disagreed across at least one evaluation.
- key_valid  out  1  key_out/unstable_mask valid.
- key_ready  in  1  consumer accepts key when high with key_valid.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky watchdog-abort flag.

## Operation
- States: IDLE, COLLECT, VOTE, OUTPUT. All outputs registered.
- IDLE: on start, clear ones_cnt[0..RESP_W-1], eval_cnt, wd_cnt; clear timeout_err; go COLLECT.
- COLLECT: puf_enable = 1. On resp_valid: ones_cnt[i] += resp_in[i]; eval_cnt += 1; wd_cnt cleared. When the strobe brings eval_cnt to NUM_EVAL, go VOTE. Without resp_valid: wd_cnt += 1; when wd_cnt reaches TIMEOUT, set timeout_err, go IDLE, no key produced.
- VOTE (one cycle): key_out[i] = (ones_cnt[i] > NUM_EVAL/2); unstable_mask[i] = (ones_cnt[i] != 0) && (ones_cnt[i] != NUM_EVAL); key_valid set; go OUTPUT.
- OUTPUT: hold key_valid, key_out, unstable_mask stable until key_valid && key_ready; then key_valid cleared, go IDLE. key_out/unstable_mask retain their values after handshake until next VOTE.
- Widths: ones_cnt[i] and eval_cnt are $clog2(NUM_EVAL+1) bits, never wrap (max NUM_EVAL); wd_cnt 16 bits.
- resp_valid outside COLLECT ignored. start outside IDLE ignored (no queueing).
- resp_valid and wd_cnt reaching TIMEOUT in the same cycle: response wins, watchdog cleared.

## Timing
- Reset values: puf_enable 0, key_out 0, unstable_mask 0, key_valid 0, busy 0, timeout_err 0; state IDLE, all counters 0.
- start at cycle T -> COLLECT, puf_enable = 1, busy = 1 at T+1.
- Final resp_valid at cycle C -> VOTE at C+1 (puf_enable 0), key_valid = 1 at C+2.
- key_ready sampled while key_valid = 1; handshake cycle H -> key_valid 0, busy 0 at H+1. key_ready high when key_valid rises completes in that same cycle.
- Earliest restart: start at H+1 -> COLLECT at H+2.
- Timeout: entry to COLLECT or last resp_valid at cycle R; with no further strobes, timeout_err = 1, busy = 0, puf_enable = 0 at R+TIMEOUT+1.
- rst mid-operation: immediate return to reset values; partial counts discarded.

## Test plan
- Stable PUF: start, 7 strobes of resp_in = 4'b1010 -> key_out 4'b1010, unstable_mask 4'b0000, key_valid 2 cycles after the 7th strobe.
- Noisy bits: bit0 high in 4 of 7, bit1 in 3 of 7, bit2 in 7 of 7, bit3 in 0 of 7 -> key_out 4'b0101, unstable_mask 4'b0011.
- Backpressure: key_ready low 10 cycles after key_valid -> key_valid, key_out, unstable_mask constant; start pulsed mid-wait ignored; key_ready high -> key_valid 0 and busy 0 next cycle.
- Timeout: start with TIMEOUT = 20, 2 strobes then none -> timeout_err 1 exactly 21 cycles after the 2nd strobe, key_valid never asserts; next start clears timeout_err.
- Reset mid-COLLECT after 3 strobes -> all outputs 0 immediately; new start plus 7 strobes of 4'b1111 -> key_out 4'b1111, mask 4'b0000 (no stale counts).
- Ignored strobes: resp_valid pulses in IDLE and OUTPUT -> counts unaffected; next vote on 7 strobes of 4'b0001 yields key_out 4'b0001.

Source files
------------

// File: rtl/puf_majority_voter.sv
// Temporal majority-vote stabiliser for the ring-oscillator PUF core.
// Collects NUM_EVAL responses, votes per bit, and hands the key plus an
// unstable-bit mask to the consumer over valid/ready. A watchdog aborts
// collection if the PUF stops producing responses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; outputs from last vote retained
// COLLECT  | PUF enabled, accumulating per-bit ones counts, watchdog live
// VOTE     | one cycle: majority and stability computed, key_valid raised
// OUTPUT   | key_valid held until the consumer accepts (key_ready)
module puf_majority_voter #(
    parameter int RESP_W   = 4,
    parameter int NUM_EVAL = 7,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              puf_enable_o,
    input  logic [RESP_W-1:0] resp_in_i,
    input  logic              resp_valid_i,
    output logic [RESP_W-1:0] key_out_o,
    output logic [RESP_W-1:0] unstable_mask_o,
    output logic              key_valid_o,
    input  logic              key_ready_i,
    output logic              busy_o,
    output logic              timeout_err_o
);

    localparam int CW = $clog2(NUM_EVAL + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VOTE,
        S_OUTPUT
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     ones_cnt_q [RESP_W];
    logic [CW-1:0]     ones_cnt_d [RESP_W];
    logic [CW-1:0]     eval_cnt_q;
    logic [CW-1:0]     eval_cnt_d;
    logic [15:0]       wd_cnt_q;
    logic [RESP_W-1:0] key_q;
    logic [RESP_W-1:0] key_d;
    logic [RESP_W-1:0] mask_q;
    logic [RESP_W-1:0] mask_d;
    logic              puf_enable_q;
    logic              key_valid_q;
    logic              busy_q;
    logic              timeout_err_q;

    // Candidate counts for the next strobe and the vote result from the current counts.
    always_comb begin
        eval_cnt_d = eval_cnt_q + CW'(1);
        key_d      = '0;
        mask_d     = '0;
        for (int i = 0; i < RESP_W; i++) begin
            ones_cnt_d[i] = ones_cnt_q[i] + CW'(resp_in_i[i]);
            key_d[i]      = (ones_cnt_q[i] > CW'(NUM_EVAL / 2));
            mask_d[i]     = (ones_cnt_q[i] != '0) && (ones_cnt_q[i] != CW'(NUM_EVAL));
        end
    end

    // Sequencer: state, counters, watchdog and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            eval_cnt_q    <= '0;
            wd_cnt_q      <= '0;
            key_q         <= '0;
            mask_q        <= '0;
            puf_enable_q  <= 1'b0;
            key_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < RESP_W; i++) begin
                ones_cnt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i < RESP_W; i++) begin
                            ones_cnt_q[i] <= '0;
                        end
                        eval_cnt_q    <= '0;
                        wd_cnt_q      <= '0;
                        timeout_err_q <= 1'b0;
                        puf_enable_q  <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    // A response in the same cycle as watchdog expiry takes priority.
                    if (resp_valid_i) begin
                        for (int i = 0; i < RESP_W; i++) begin
                            ones_cnt_q[i] <= ones_cnt_d[i];
                        end
                        eval_cnt_q <= eval_cnt_d;
                        wd_cnt_q   <= '0;
                        if (eval_cnt_d == CW'(NUM_EVAL)) begin
                            puf_enable_q <= 1'b0;
                            state_q      <= S_VOTE;
                        end
                    end else if (wd_cnt_q == 16'(TIMEOUT - 1)) begin
                        timeout_err_q <= 1'b1;
                        puf_enable_q  <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 16'd1;
                    end
                end
                S_VOTE: begin
                    key_q       <= key_d;
                    mask_q      <= mask_d;
                    key_valid_q <= 1'b1;
                    state_q     <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (key_valid_q && key_ready_i) begin
                        key_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign puf_enable_o    = puf_enable_q;
    assign key_out_o       = key_q;
    assign unstable_mask_o = mask_q;
    assign key_valid_o     = key_valid_q;
    assign busy_o          = busy_q;
    assign timeout_err_o   = timeout_err_q;

endmodule

// File: tb/tb_puf_majority_voter.sv
// Self-checking bench for puf_majority_voter: per-feature tasks, expected
// keys computed by a bit-counting model and queued on a scoreboard.
module tb_puf_majority_voter;

    localparam int RW = 4;
    localparam int NE = 7;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          puf_enable_o;
    logic [RW-1:0] resp_in_i = '0;
    logic          resp_valid_i = 1'b0;
    logic [RW-1:0] key_out_o;
    logic [RW-1:0] unstable_mask_o;
    logic          key_valid_o;
    logic          key_ready_i = 1'b0;
    logic          busy_o;
    logic          timeout_err_o;

    int checks   = 0;
    int failures = 0;
    logic [2*RW-1:0] sb_q [$];

    puf_majority_voter #(
        .RESP_W  (RW),
        .NUM_EVAL(NE),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .puf_enable_o   (puf_enable_o),
        .resp_in_i      (resp_in_i),
        .resp_valid_i   (resp_valid_i),
        .key_out_o      (key_out_o),
        .unstable_mask_o(unstable_mask_o),
        .key_valid_o    (key_valid_o),
        .key_ready_i    (key_ready_i),
        .busy_o         (busy_o),
        .timeout_err_o  (timeout_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*RW-1:0] vote_model(input logic [NE-1:0][RW-1:0] p);
        logic [RW-1:0] k;
        logic [RW-1:0] m;
        int c;
        k = '0;
        m = '0;
        for (int b = 0; b < RW; b++) begin
            c = 0;
            for (int e = 0; e < NE; e++) c += int'(p[e][b]);
            k[b] = (c > NE / 2);
            m[b] = (c != 0) && (c != NE);
        end
        return {k, m};
    endfunction

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Drives NE strobes (optional idle gaps) and queues the expected result.
    task automatic send_resps(input logic [NE-1:0][RW-1:0] p, input int max_gap);
        for (int e = 0; e < NE; e++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
            resp_in_i    = p[e];
            resp_valid_i = 1'b1;
            tick();
            resp_valid_i = 1'b0;
            resp_in_i    = RW'($urandom);
        end
        sb_q.push_back(vote_model(p));
    endtask

    // Counts cycles from the one after the final strobe (1) until key_valid.
    task automatic wait_key(output int n);
        n = 1;
        while (key_valid_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (puf_enable_o !== 1'b0) begin failures++; $display("FAIL reset_puf_enable: got %b want 0", puf_enable_o); end
        checks++; if (key_out_o !== '0) begin failures++; $display("FAIL reset_key_out: got %h want 0", key_out_o); end
        checks++; if (unstable_mask_o !== '0) begin failures++; $display("FAIL reset_mask: got %h want 0", unstable_mask_o); end
        checks++; if (key_valid_o !== 1'b0) begin failures++; $display("FAIL reset_key_valid: got %b want 0", key_valid_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (timeout_err_o !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err_o); end
    endtask

    task automatic test_stable();
        logic [NE-1:0][RW-1:0] p;
        logic [2*RW-1:0] exp;
        int n;
        for (int e = 0; e < NE; e++) p[e] = 4'b1010;
        key_ready_i = 1'b1;
        do_start();
        checks++; if ({puf_enable_o, busy_o} !== 2'b11) begin failures++; $display("FAIL stable_collect_entry: got en/busy=%b want 11", {puf_enable_o, busy_o}); end
        send_resps(p, 0);
        checks++; if (puf_enable_o !== 1'b0) begin failures++; $display("FAIL stable_vote_puf_enable: got %b want 0", puf_enable_o); end
        wait_key(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL stable_latency: got %0d want 2", n); end
        exp = sb_q.pop_front();
        checks++; if ({key_out_o, unstable_mask_o} !== exp) begin failures++; $display("FAIL stable_key: got %h want %h", {key_out_o, unstable_mask_o}, exp); end
        checks++; if (key_out_o !== 4'b1010) begin failures++; $display("FAIL stable_key_literal: got %b want 1010", key_out_o); end
        tick();
        checks++; if ({key_valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL stable_handshake: got valid/busy=%b want 00", {key_valid_o, busy_o}); end
    endtask

    task automatic test_noisy();
        logic [NE-1:0][RW-1:0] p;
        logic [2*RW-1:0] exp;
        int n;
        for (int e = 0; e < NE; e++) begin
            p[e][0] = (e < 4);
            p[e][1] = (e >= 4);
            p[e][2] = 1'b1;
            p[e][3] = 1'b0;
        end
        key_ready_i = 1'b1;
        do_start();
        send_resps(p, 3);
        wait_key(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL noisy_latency: got %0d want 2", n); end
        exp = sb_q.pop_front();
        checks++; if ({key_out_o, unstable_mask_o} !== exp) begin failures++; $display("FAIL noisy_key: got %h want %h", {key_out_o, unstable_mask_o}, exp); end
        checks++; if ({key_out_o, unstable_mask_o} !== 8'b0101_0011) begin failures++; $display("FAIL noisy_key_literal: got %b want 01010011", {key_out_o, unstable_mask_o}); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [NE-1:0][RW-1:0] p;
        logic [2*RW-1:0] exp;
        int n;
        logic [RW-1:0] k;
        logic [RW-1:0] m;
        for (int e = 0; e < NE; e++) p[e] = RW'($urandom);
        key_ready_i = 1'b0;
        do_start();
        send_resps(p, 2);
        wait_key(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL bp_latency: got %0d want 2", n); end
        exp = sb_q.pop_front();
        checks++; if ({key_out_o, unstable_mask_o} !== exp) begin failures++; $display("FAIL bp_key: got %h want %h", {key_out_o, unstable_mask_o}, exp); end
        k = exp[2*RW-1:RW];
        m = exp[RW-1:0];
        for (int i = 0; i < 10; i++) begin
            start_i = (i == 4);
            tick();
            checks++; if ({key_valid_o, key_out_o, unstable_mask_o} !== {1'b1, k, m}) begin failures++; $display("FAIL bp_hold cycle %0d: got %h want %h", i, {key_valid_o, key_out_o, unstable_mask_o}, {1'b1, k, m}); end
        end
        start_i = 1'b0;
        key_ready_i = 1'b1;
        tick();
        checks++; if ({key_valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL bp_release: got valid/busy=%b want 00", {key_valid_o, busy_o}); end
        tick();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL bp_start_not_queued: got busy=%b want 0", busy_o); end
        checks++; if ({key_out_o, unstable_mask_o} !== {k, m}) begin failures++; $display("FAIL bp_key_retained: got %h want %h", {key_out_o, unstable_mask_o}, {k, m}); end
    endtask

    task automatic test_timeout();
        int n;
        logic seen_kv;
        int sb_before;
        sb_before = sb_q.size();
        seen_kv = 1'b0;
        key_ready_i = 1'b1;
        do_start();
        resp_in_i = 4'b1111;
        resp_valid_i = 1'b1;
        tick();
        resp_valid_i = 1'b0;
        repeat (3) tick();
        resp_valid_i = 1'b1;
        tick();
        resp_valid_i = 1'b0;
        n = 1;
        while (timeout_err_o !== 1'b1 && n < 100) begin
            if (key_valid_o === 1'b1) seen_kv = 1'b1;
            tick();
            n++;
        end
        checks++; if (n !== TO + 1) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", n, TO + 1); end
        checks++; if ({busy_o, puf_enable_o} !== 2'b00) begin failures++; $display("FAIL timeout_idle: got busy/en=%b want 00", {busy_o, puf_enable_o}); end
        checks++; if ({seen_kv, key_valid_o} !== 2'b00) begin failures++; $display("FAIL timeout_no_key: got seen/valid=%b want 00", {seen_kv, key_valid_o}); end
        checks++; if (sb_q.size() !== sb_before) begin failures++; $display("FAIL timeout_sb: got %0d want %0d", sb_q.size(), sb_before); end
        tick();
        checks++; if (timeout_err_o !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b want 1", timeout_err_o); end
        do_start();
        checks++; if ({timeout_err_o, busy_o} !== 2'b01) begin failures++; $display("FAIL timeout_clear_on_start: got err/busy=%b want 01", {timeout_err_o, busy_o}); end
    endtask

    task automatic test_reset_mid();
        logic [NE-1:0][RW-1:0] p;
        logic [2*RW-1:0] exp;
        int n;
        do_start();
        for (int e = 0; e < 3; e++) begin
            resp_in_i = 4'b0000;
            resp_valid_i = 1'b1;
            tick();
            resp_valid_i = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({puf_enable_o, key_out_o, unstable_mask_o, key_valid_o, busy_o, timeout_err_o} !== '0) begin failures++; $display("FAIL rst_mid_outputs: got %h want 0", {puf_enable_o, key_out_o, unstable_mask_o, key_valid_o, busy_o, timeout_err_o}); end
        tick();
        rst = 1'b0;
        tick();
        for (int e = 0; e < NE; e++) p[e] = 4'b1111;
        key_ready_i = 1'b1;
        do_start();
        send_resps(p, 1);
        wait_key(n);
        checks++; if (n !== 2) begin failures++; $display("FAIL rst_mid_latency: got %0d want 2", n); end
        exp = sb_q.pop_front();
        checks++; if ({key_out_o, unstable_mask_o} !== exp) begin failures++; $display("FAIL rst_mid_key: got %h want %h", {key_out_o, unstable_mask_o}, exp); end
        tick();
    endtask

    task automatic test_ignored();
        logic [NE-1:0][RW-1:0] p;
        logic [2*RW-1:0] exp;
        int n;
        for (int e = 0; e < NE; e++) p[e] = 4'b0001;
        for (int r = 0; r < 2; r++) begin
            resp_in_i = 4'b1111;
            for (int i = 0; i < 3; i++) begin
                resp_valid_i = 1'b1;
                tick();
                resp_valid_i = 1'b0;
                tick();
            end
            checks++; if ({busy_o, puf_enable_o} !== 2'b00) begin failures++; $display("FAIL ign_idle_%0d: got busy/en=%b want 00", r, {busy_o, puf_enable_o}); end
            key_ready_i = 1'b0;
            do_start();
            send_resps(p, 0);
            wait_key(n);
            checks++; if (n !== 2) begin failures++; $display("FAIL ign_latency_%0d: got %0d want 2", r, n); end
            exp = sb_q.pop_front();
            checks++; if ({key_out_o, unstable_mask_o} !== exp) begin failures++; $display("FAIL ign_key_%0d: got %h want %h", r, {key_out_o, unstable_mask_o}, exp); end
            resp_in_i = 4'b1111;
            for (int i = 0; i < 2; i++) begin
                resp_valid_i = 1'b1;
                tick();
                resp_valid_i = 1'b0;
            end
            checks++; if ({key_valid_o, key_out_o, unstable_mask_o} !== {1'b1, exp}) begin failures++; $display("FAIL ign_output_hold_%0d: got %h want %h", r, {key_valid_o, key_out_o, unstable_mask_o}, {1'b1, exp}); end
            key_ready_i = 1'b1;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [NE-1:0][RW-1:0] p;
        logic [2*RW-1:0] exp;
        int n;
        key_ready_i = 1'b1;
        for (int v = 0; v < 4; v++) begin
            for (int e = 0; e < NE; e++) p[e] = RW'($urandom);
            do_start();
            checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_restart_%0d: got busy=%b want 1", v, busy_o); end
            send_resps(p, 2);
            wait_key(n);
            checks++; if (n !== 2) begin failures++; $display("FAIL b2b_latency_%0d: got %0d want 2", v, n); end
            exp = sb_q.pop_front();
            checks++; if ({key_out_o, unstable_mask_o} !== exp) begin failures++; $display("FAIL b2b_key_%0d: got %h want %h", v, {key_out_o, unstable_mask_o}, exp); end
            tick();
            checks++; if ({key_valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL b2b_done_%0d: got valid/busy=%b want 00", v, {key_valid_o, busy_o}); end
        end
        checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL sb_empty: got %0d entries want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_stable();
        test_noisy();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
